// File: rtl/fp_result_buffer_if.sv
// Handshake bundle between the FP adder, the result buffer and the result consumer.
//   in_valid/in_data/in_ready      : adder -> buffer, valid/ready
//   out_valid/out_data/out_flags   : buffer -> consumer, valid/ready
//   out_ready                      : consumer -> buffer
// Modport master is the environment side (adder plus consumer); slave is the buffer.
interface fp_result_buffer_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_flags;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_flags
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_flags
   );
endinterface

// File: rtl/fp_result_buffer.sv
// Result buffer behind the single-precision FP adder.
// Classifies each sum as zero/subnormal/inf/NaN, optionally canonicalises NaNs and flushes
// subnormals, then queues {flags, data} in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : in_valid/in_data/in_ready and out_valid/out_ready/out_data/out_flags
//                       out_flags = {nan, inf, sub, zero}
//   cnt_clr           : synchronous clear of nan_cnt, inf_cnt and drop
//   nan_cnt, inf_cnt  : saturating counts of accepted NaN / infinity results
//   drop              : sticky, set when in_valid arrives while in_ready is low
module fp_result_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_W     = 16,
   parameter bit          CANON_NAN = 1'b1,
   parameter bit          FTZ       = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   fp_result_buffer_if.slave  bus,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   nan_cnt,
   output logic [CNT_W-1:0]   inf_cnt,
   output logic               drop
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OccW = $clog2(DEPTH + 1);
   localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);
   localparam logic [31:0] CanonNan = 32'h7FC0_0000;

   // Classification of the raw adder result
   logic exp_zero, exp_ones, mant_nz;
   logic is_zero, is_sub, is_inf, is_nan;

   assign exp_zero = (bus.in_data[30:23] == 8'h00);
   assign exp_ones = (bus.in_data[30:23] == 8'hFF);
   assign mant_nz  = |bus.in_data[22:0];
   assign is_zero  = exp_zero & ~mant_nz;
   assign is_sub   = exp_zero &  mant_nz;
   assign is_inf   = exp_ones & ~mant_nz;
   assign is_nan   = exp_ones &  mant_nz;

   logic [31:0] proc_data;
   logic [3:0]  proc_flags;

   always_comb begin
      proc_data  = bus.in_data;
      proc_flags = {is_nan, is_inf, is_sub, is_zero};
      if (CANON_NAN && is_nan) begin
         proc_data = CanonNan;
      end
      // A flushed subnormal is reported as the signed zero it became
      if (FTZ && is_sub) begin
         proc_data  = {bus.in_data[31], 31'b0};
         proc_flags = 4'b0001;
      end
   end

   // FIFO state
   logic [35:0]     mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0] occ_q, occ_d;
   logic            push, pop;
   logic            in_ready_int, out_valid_int;

   assign in_ready_int  = (occ_q != OccFull);
   assign out_valid_int = (occ_q != '0);
   assign push          = bus.in_valid & in_ready_int;
   assign pop           = out_valid_int & bus.out_ready;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         occ_d = occ_q + OccW'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - OccW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset: the output is masked whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {proc_flags, proc_data};
      end
   end

   logic [35:0] head;
   assign head = mem_q[rd_ptr_q];

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = out_valid_int ? head[31:0]  : 32'h0;
   assign bus.out_flags = out_valid_int ? head[35:32] : 4'h0;

   // Status counters and sticky drop flag; cnt_clr wins over any same-cycle event
   logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
   logic [CNT_W-1:0] inf_cnt_q, inf_cnt_d;
   logic             drop_q, drop_d;

   always_comb begin
      nan_cnt_d = nan_cnt_q;
      inf_cnt_d = inf_cnt_q;
      drop_d    = drop_q;
      if (cnt_clr) begin
         nan_cnt_d = '0;
         inf_cnt_d = '0;
         drop_d    = 1'b0;
      end else begin
         if (push && is_nan && (nan_cnt_q != '1)) begin
            nan_cnt_d = nan_cnt_q + CNT_W'(1);
         end
         if (push && is_inf && (inf_cnt_q != '1)) begin
            inf_cnt_d = inf_cnt_q + CNT_W'(1);
         end
         if (bus.in_valid && !in_ready_int) begin
            drop_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nan_cnt_q <= '0;
         inf_cnt_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         nan_cnt_q <= nan_cnt_d;
         inf_cnt_q <= inf_cnt_d;
         drop_q    <= drop_d;
      end
   end

   assign nan_cnt = nan_cnt_q;
   assign inf_cnt = inf_cnt_q;
   assign drop    = drop_q;

endmodule

// File: doc/fp_result_buffer.md
Name: fp_result_buffer

Overview:
- Downstream stage of the 32-bit single-precision FP adder.
- Captures each IEEE-754 sum the adder produces and classifies it as zero, subnormal, infinity or NaN.
- Optionally canonicalises NaNs and flushes subnormals to zero, then queues the result in a small FIFO with a valid/ready interface to the consumer.
- Keeps saturating exception counters and a sticky drop flag for debug/status readout.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, 16, width of each exception counter
CANON_NAN, 1, when 1 every NaN is replaced by 32'h7FC00000
FTZ, 1, when 1 subnormals are replaced by a signed zero (sign kept, exp/mantissa = 0)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  adder result valid this cycle
in_data  input  32  adder result {sign, exp[7:0], mant[22:0]}
in_ready  output  1  buffer can accept (FIFO not full)
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  32  head result after NaN/FTZ processing
out_flags  output  4  head classification {nan, inf, sub, zero}
cnt_clr  input  1  synchronous clear of counters and drop flag
nan_cnt  output  CNT_W  NaN results accepted, saturating
inf_cnt  output  CNT_W  infinity results accepted, saturating
drop  output  1  sticky: in_valid seen while in_ready low

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; read/write pointers and occupancy = 0.
  - out_valid=0, out_data=0, out_flags=0, in_ready=1, nan_cnt=0, inf_cnt=0, drop=0.
  - Reset mid-operation discards all queued entries immediately.
- Classification, combinational on in_data; exactly one flag or none:
  - zero: exp==0, mant==0.
  - sub: exp==0, mant!=0.
  - inf: exp==255, mant==0.
  - nan: exp==255, mant!=0.
  - Normal numbers give flags=0.
- Processing before storage:
  - nan with CANON_NAN=1: data becomes 32'h7FC00000; flags stay nan.
  - sub with FTZ=1: data becomes {sign, 31'b0}; stored flags = zero (sub cleared).
  - FTZ=0: subnormal stored unchanged, flags = sub.
- Push: in_valid && in_ready. The processed entry {flags, data} is written at the write pointer, and the pointer increments modulo DEPTH.
- Pop: out_valid && out_ready. The read pointer increments modulo DEPTH.
- Occupancy register 0..DEPTH:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
- in_ready = (occupancy != DEPTH), registered-state derived. There is no same-cycle pass-through when full: a pop in the full cycle frees a slot only from the next cycle.
- out_valid = (occupancy != 0). out_data/out_flags show the head entry and stay stable while out_valid && !out_ready.
- Latency: a result pushed at edge N is visible on out_valid/out_data after edge N, even when the FIFO was empty. There is no combinational bypass.
- Empty + out_ready: no pop; pointers unchanged.
- Counters:
  - nan_cnt increments on each accepted push whose raw in_data is NaN.
  - inf_cnt increments on each accepted inf push.
  - Both saturate at all-ones.
  - Dropped (not accepted) inputs are never counted.
- drop is set on any cycle with in_valid && !in_ready and stays set until cnt_clr or reset.
- cnt_clr has priority: when it coincides with an increment or a drop event, the result is 0 / drop=0 for that cycle. cnt_clr does not affect FIFO contents.

Test Plan:
- Adder sum 32'h40EC0000 (7.375) pushed into an empty buffer with out_ready=1 -> next cycle out_valid=1, out_data=40EC0000, out_flags=0000; popped; FIFO empty again, counters 0.
- Push 32'h7F800000, then 32'h7FC00001, then 32'hFF800000 -> out_data sequence 7F800000, 7FC00000, FF800000; flags 0100, 1000, 0100; inf_cnt=2, nan_cnt=1.
- FTZ=1: push 32'h80000010 -> out_data=80000000, flags=0001. FTZ=0: same input -> out_data=80000010, flags=0010.
- out_ready=0, five pushes with DEPTH=4 -> in_ready low after the fourth; fifth dropped, drop=1, no counter change. Then out_ready=1 drains entries 1-4 in order. Simultaneous push/pop at occupancy 2 keeps occupancy 2.
- Wrap-around: 10 consecutive pushes/pops alternating fill levels -> output order matches input order. cnt_clr pulsed in the same cycle as a NaN push -> nan_cnt=0 afterwards and the NaN entry is still queued.
- Assert rst_n low asynchronously mid-clock with 3 entries queued -> out_valid, counters and drop go 0 immediately, in_ready=1. After release, a new push behaves as from the empty state.
